// File: rtl/seq_gen_serial.sv
// rtl/seq_gen_serial.sv - serial pattern generator with repeat count and zero-bit gap
module seq_gen_serial #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             seq_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  logic [1:0]       state;
  logic [PAT_W-1:0] shreg;
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] rem_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_q;

  // Sequencer: capture on start, shift pattern bits out, count repeats and gap cycles
  always_ff @(posedge clk) begin
    if (rst || (abort && state != ST_IDLE)) begin
      // Reset and abort both return to IDLE with every counter cleared, no done pulse
      state   <= ST_IDLE;
      shreg   <= '0;
      pat_q   <= '0;
      bit_idx <= '0;
      rem_cnt <= '0;
      gap_cnt <= '0;
      gap_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // abort here is only relevant when paired with start: it drops the request
          if (start && !abort) begin
            if (repeat_cnt != '0) begin
              pat_q   <= pattern;
              shreg   <= pattern;
              rem_cnt <= repeat_cnt;
              gap_q   <= gap_len;
              bit_idx <= '0;
              state   <= ST_SEND;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_SEND: begin
          shreg   <= {shreg[PAT_W-2:0], 1'b0};
          bit_idx <= bit_idx + IDX_W'(1);
          if (bit_idx == LAST_IDX) begin
            bit_idx <= '0;
            if (rem_cnt != '0) begin
              rem_cnt <= rem_cnt - CNT_W'(1);
            end
            if (rem_cnt <= CNT_W'(1)) begin
              state <= ST_DONE;
            end else if (gap_q == '0) begin
              shreg <= pat_q;
            end else begin
              gap_cnt <= gap_q;
              state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt <= '0;
            shreg   <= pat_q;
            bit_idx <= '0;
            state   <= ST_SEND;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from registered state only
  assign seq_out   = (state == ST_SEND) & shreg[PAT_W-1];
  assign bit_valid = (state == ST_SEND);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign state_out = state;

endmodule

// File: tb/tb_seq_gen_serial.sv
// tb/tb_seq_gen_serial.sv - table-driven and sequence checks for seq_gen_serial
`timescale 1ns/1ps
module tb_seq_gen_serial;

  localparam logic [1:0] I = 2'd0;
  localparam logic [1:0] S = 2'd1;
  localparam logic [1:0] G = 2'd2;
  localparam logic [1:0] D = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] pattern = '0;
  logic [3:0] repeat_cnt = '0;
  logic [3:0] gap_len = '0;
  logic       seq_out, bit_valid, busy, done;
  logic [1:0] state_out;

  int checks = 0;
  int passed = 0;

  seq_gen_serial #(.PAT_W(3), .CNT_W(4), .GAP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .gap_len(gap_len), .abort(abort),
    .seq_out(seq_out), .bit_valid(bit_valid), .busy(busy),
    .done(done), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, s, a;
    logic [2:0] pat;
    logic [3:0] rc, gl;
    logic       eseq;
    logic [1:0] est;
  } vec_t;

  vec_t vq[$];

  // Expected outputs after the edge that samples these inputs
  function automatic void v(input logic r, s, a, input logic [2:0] pat,
                            input logic [3:0] rc, gl, input logic eseq,
                            input logic [1:0] est);
    vec_t t;
    t.r = r; t.s = s; t.a = a; t.pat = pat; t.rc = rc; t.gl = gl;
    t.eseq = eseq; t.est = est;
    vq.push_back(t);
  endfunction

  function automatic void n(input logic eseq, input logic [1:0] est);
    v(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, eseq, est);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Run one transfer, observing every cycle until busy drops
  task automatic run_transfer(input logic [2:0] pat, input logic [3:0] rc,
                              input logic [3:0] gl, output int busy_n,
                              output int valid_n, output int gap_n,
                              output int done_n, output int det_n);
    int ds;
    busy_n = 0; valid_n = 0; gap_n = 0; done_n = 0; det_n = 0; ds = 0;
    @(negedge clk);
    start = 1'b1; pattern = pat; repeat_cnt = rc; gap_len = gl;
    @(negedge clk);
    start = 1'b0; pattern = 3'd0; repeat_cnt = 4'd0; gap_len = 4'd0;
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      busy_n++;
      if (done) done_n++;
      if (state_out == G && !bit_valid && !seq_out) gap_n++;
      if (bit_valid) begin
        valid_n++;
        // Non-overlapping 101 detector fed only with valid bits
        case (ds)
          0: ds = seq_out ? 1 : 0;
          1: ds = seq_out ? 1 : 2;
          default: begin
            if (seq_out) det_n++;
            ds = 0;
          end
        endcase
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int bn, vn, gn, dn, tn;
    logic [5:0] act, exp;

    // reset
    v(1, 0, 0, 3'd0, 4'd0, 4'd0, 0, I);
    // single pattern 101, R=1, G=0
    v(0, 1, 0, 3'b101, 4'd1, 4'd0, 1, S); n(0, S); n(1, S); n(0, D); n(0, I);
    // 101, R=2, G=2
    v(0, 1, 0, 3'b101, 4'd2, 4'd2, 1, S); n(0, S); n(1, S); n(0, G); n(0, G);
    n(1, S); n(0, S); n(1, S); n(0, D); n(0, I);
    // R=0
    v(0, 1, 0, 3'b101, 4'd0, 4'd3, 0, D); n(0, I);
    // back-to-back R=3, G=0
    v(0, 1, 0, 3'b101, 4'd3, 4'd0, 1, S); n(0, S); n(1, S);
    n(1, S); n(0, S); n(1, S); n(1, S); n(0, S); n(1, S); n(0, D); n(0, I);
    // start while busy (SEND then GAP) with other parameters is ignored
    v(0, 1, 0, 3'b110, 4'd2, 4'd1, 1, S);
    v(0, 1, 0, 3'b001, 4'd7, 4'd0, 1, S);
    v(0, 1, 0, 3'b001, 4'd7, 4'd0, 0, S);
    v(0, 1, 0, 3'b010, 4'd5, 4'd3, 0, G);
    v(0, 1, 0, 3'b010, 4'd5, 4'd3, 1, S); n(1, S); n(0, S); n(0, D); n(0, I);
    // abort during 2nd bit
    v(0, 1, 0, 3'b101, 4'd1, 4'd0, 1, S); n(0, S);
    v(0, 0, 1, 3'd0, 4'd0, 4'd0, 0, I); n(0, I); n(0, I);
    // reset in GAP, then a clean transfer
    v(0, 1, 0, 3'b101, 4'd2, 4'd2, 1, S); n(0, S); n(1, S); n(0, G);
    v(1, 0, 0, 3'd0, 4'd0, 4'd0, 0, I); n(0, I);
    v(0, 1, 0, 3'b111, 4'd1, 4'd0, 1, S); n(1, S); n(1, S); n(0, D); n(0, I);
    // start and abort together in IDLE
    v(0, 1, 1, 3'b101, 4'd1, 4'd0, 0, I); n(0, I);
    // abort in DONE
    v(0, 1, 0, 3'b101, 4'd0, 4'd0, 0, D);
    v(0, 0, 1, 3'd0, 4'd0, 4'd0, 0, I); n(0, I);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].r; start = vq[i].s; abort = vq[i].a;
      pattern = vq[i].pat; repeat_cnt = vq[i].rc; gap_len = vq[i].gl;
      @(posedge clk);
      #1;
      act = {seq_out, bit_valid, busy, done, state_out};
      exp = {vq[i].eseq, vq[i].est == S, vq[i].est != I, vq[i].est == D, vq[i].est};
      checks++;
      if (act === exp) passed++;
      else $display("FAIL vec%0d: got seq/vld/busy/done/st=%b expected %b", i, act, exp);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; abort = 1'b0;

    // loopback: R=3, G=1 into a 101 detector
    run_transfer(3'b101, 4'd3, 4'd1, bn, vn, gn, dn, tn);
    check("loop_busy", bn, 3*3 + 2*1 + 1);
    check("loop_valid", vn, 9);
    check("loop_gap", gn, 2);
    check("loop_done", dn, 1);
    check("loop_detect", tn, 3);
    check("loop_idle", busy, 0);

    // maximum gap length
    run_transfer(3'b111, 4'd2, 4'd15, bn, vn, gn, dn, tn);
    check("maxgap_busy", bn, 2*3 + 15 + 1);
    check("maxgap_gap", gn, 15);
    check("maxgap_valid", vn, 6);
    check("maxgap_done", dn, 1);

    // maximum repeat count, back-to-back
    run_transfer(3'b100, 4'd15, 4'd0, bn, vn, gn, dn, tn);
    check("maxrep_busy", bn, 15*3 + 1);
    check("maxrep_valid", vn, 45);
    check("maxrep_done", dn, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
